clock_gen_ctrl: RTL and testbench



---
 rtl/clock_gen_ctrl.sv | 141 ++++++++++++++
 tb/tb_clock_gen_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_gen_ctrl.sv
// Purpose: programmable clk_in divider with start/stop sequencing and a glitch-free divisor update port.
// Latency: first clk_out rise H+1 cycles after RUN entry; new H and stops take effect at the next full-period boundary.
// Backpressure: cfg_ready low while a divisor update or stop is pending (PEND/STOP); high in IDLE and RUN.
module clock_gen_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 24
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;

  logic             at_top;
  logic             boundary;
  logic             cfg_acc;

  // Ready depends only on the current state so the host sees no path from its own inputs.
  assign cfg_ready = (state_q == IDLE) || (state_q == RUN);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign at_top    = (cnt_q == half_q);
  // A falling edge that completes a full period: the only safe point to change H or stop.
  assign boundary  = at_top && clk_out_q;

  // Next-state, half-period counter and divided-clock logic.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;

    // Free-running count in every active state; IDLE overrides below.
    if (at_top) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        // Direct write is safe here because nothing is being generated.
        if (cfg_acc) begin
          half_d = cfg_half;
        end
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A cfg accept wins over a stop; the stop is re-evaluated once the update lands.
        if (cfg_acc) begin
          shadow_d = cfg_half;
          state_d  = PEND;
        end else if (!en) begin
          state_d = STOP;
        end
      end
      PEND: begin
        if (boundary) begin
          half_d    = shadow_q;
          cnt_d     = '0;
          clk_out_d = 1'b0;
          state_d   = en ? RUN : IDLE;
        end
      end
      STOP: begin
        // Returning to RUN keeps counting, so the phase is undisturbed.
        if (en) begin
          state_d = RUN;
        end else if (boundary) begin
          cnt_d     = '0;
          clk_out_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase
  end

  // Tick marks the cycle clk_out becomes high; running mirrors the registered state.
  always_comb begin
    tick_d    = clk_out_d && !clk_out_q;
    running_d = (state_d != IDLE);
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      half_q    <= RST_HALF;
      shadow_q  <= '0;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign running = running_q;

endmodule

// File: tb/tb_clock_gen_ctrl.sv
// Purpose: scoreboard bench for clock_gen_ctrl; expected clk_out phase lengths are queued as stimulus is applied.
// Latency: phases are compared as each clk_out level completes, sampled on the falling clk_in edge.
// Backpressure: cfg writes are one-cycle pulses issued only where cfg_ready is expected high.
module tb_clock_gen_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic [15:0] cfg_half;
  logic        cfg_ready;
  logic        clk_out;
  logic        tick;
  logic        running;

  typedef struct {
    bit lvl;
    int len;
  } phase_t;

  phase_t exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  bit     mon_en = 1'b1;

  clock_gen_ctrl #(.CNT_W(16), .DEFAULT_HALF(24)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: measures each completed clk_out phase and checks tick against the observed rise.
  bit     prev_clk = 1'b0;
  bit     seen_edge = 1'b0;
  int     run_len = 0;
  phase_t ph;
  always @(negedge clk_in) begin
    if (!rst_n) begin
      prev_clk  = 1'b0;
      seen_edge = 1'b0;
      run_len   = 0;
    end else begin
      if (mon_en) chk_eq("tick", tick, (clk_out && !prev_clk));
      if (clk_out !== prev_clk) begin
        if (seen_edge && mon_en && exp_q.size() > 0) begin
          ph = exp_q.pop_front();
          chk_eq(prev_clk ? "high_len" : "low_len", run_len, ph.len);
          chk_eq("phase_lvl", prev_clk, ph.lvl);
        end
        seen_edge = 1'b1;
        run_len   = 1;
      end else begin
        run_len++;
      end
      prev_clk = clk_out;
    end
  end

  task automatic push_ph(input bit l, input int len);
    phase_t p;
    p.lvl = l;
    p.len = len;
    exp_q.push_back(p);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    exp_q.delete();
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
  endtask

  // One-cycle cfg offer; en is set alongside so a same-cycle start can be exercised.
  task automatic cfg_write(input logic [15:0] h, input logic en_v);
    cfg_valid = 1'b1;
    cfg_half  = h;
    en        = en_v;
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  // Counts samples from the current one until clk_out is first seen high.
  task automatic measure_rise(output int lat);
    lat = 0;
    while (clk_out !== 1'b1 && lat < 300) begin
      @(negedge clk_in);
      lat++;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    chk_eq(tag, exp_q.size(), 0);
  endtask

  int lat;
  int tcnt;
  int hcnt;

  initial begin
    // Reset state.
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    @(negedge clk_in);
    chk_eq("rst_clk_out", clk_out, 0);
    chk_eq("rst_tick", tick, 0);
    chk_eq("rst_running", running, 0);
    chk_eq("rst_cfg_ready", cfg_ready, 1);

    // Default divisor: 25 high / 25 low, first rise 25 cycles after RUN entry.
    do_reset();
    en = 1'b1;
    @(negedge clk_in);
    chk_eq("def_running", running, 1);
    measure_rise(lat);
    chk_eq("def_rise_lat", lat, 25);
    push_ph(1, 25); push_ph(0, 25); push_ph(1, 25); push_ph(0, 25);
    tcnt = tick;
    for (int i = 1; i < 150; i++) begin
      @(negedge clk_in);
      tcnt += tick;
    end
    chk_eq("def_tick_count", tcnt, 3);
    wait_drain("def_drain");

    // IDLE write of H=2 with en low, then start: 3/3 phases.
    do_reset();
    chk_eq("idle_cfg_ready", cfg_ready, 1);
    cfg_write(16'd2, 1'b0);
    chk_eq("idle_stays", running, 0);
    en = 1'b1;
    @(negedge clk_in);
    measure_rise(lat);
    chk_eq("h2_rise_lat", lat, 3);
    push_ph(1, 3); push_ph(0, 3); push_ph(1, 3); push_ph(0, 3);
    wait_drain("h2_drain");

    // H=0 written in the same cycle as en: divide-by-2 from the start.
    do_reset();
    cfg_write(16'd0, 1'b1);
    measure_rise(lat);
    chk_eq("h0_rise_lat", lat, 1);
    push_ph(1, 1); push_ph(0, 1); push_ph(1, 1); push_ph(0, 1);
    wait_drain("h0_drain");

    // Update H 2->5 mid high phase: current period completes, then 6/6.
    do_reset();
    cfg_write(16'd2, 1'b1);
    measure_rise(lat);
    chk_eq("upd_rise_lat", lat, 3);
    push_ph(1, 3); push_ph(0, 6); push_ph(1, 6); push_ph(0, 6);
    @(negedge clk_in);
    cfg_valid = 1'b1;
    cfg_half  = 16'd5;
    @(negedge clk_in);
    cfg_valid = 1'b0;
    chk_eq("upd_rdy_drop", cfg_ready, 0);
    @(negedge clk_in);
    chk_eq("upd_fall", clk_out, 0);
    chk_eq("upd_rdy_back", cfg_ready, 1);
    wait_drain("upd_drain");

    // Update H 2->4 offered on a boundary cycle: one more 3/3 period, then 5/5.
    do_reset();
    cfg_write(16'd2, 1'b1);
    measure_rise(lat);
    chk_eq("bnd_rise_lat", lat, 3);
    push_ph(1, 3); push_ph(0, 3); push_ph(1, 3);
    push_ph(0, 5); push_ph(1, 5); push_ph(0, 5);
    repeat (2) @(negedge clk_in);
    cfg_valid = 1'b1;
    cfg_half  = 16'd4;
    @(negedge clk_in);
    cfg_valid = 1'b0;
    chk_eq("bnd_rdy_drop", cfg_ready, 0);
    wait_drain("bnd_drain");

    // Stop mid high phase with H=3: high completes at 4, then quiet IDLE.
    do_reset();
    cfg_write(16'd3, 1'b1);
    measure_rise(lat);
    chk_eq("stop_rise_lat", lat, 4);
    push_ph(1, 4);
    @(negedge clk_in);
    en = 1'b0;
    wait_drain("stop_drain");
    chk_eq("stop_running", running, 0);
    chk_eq("stop_clk_low", clk_out, 0);
    tcnt = 0;
    hcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      tcnt += tick;
      hcnt += clk_out;
    end
    chk_eq("stop_no_tick", tcnt, 0);
    chk_eq("stop_no_high", hcnt, 0);
    chk_eq("stop_rdy", cfg_ready, 1);

    // Re-raise en while in STOP: phases continue undisturbed.
    do_reset();
    cfg_write(16'd3, 1'b1);
    measure_rise(lat);
    chk_eq("resume_rise_lat", lat, 4);
    push_ph(1, 4); push_ph(0, 4); push_ph(1, 4); push_ph(0, 4);
    @(negedge clk_in);
    en = 1'b0;
    @(negedge clk_in);
    chk_eq("resume_stop_rdy", cfg_ready, 0);
    chk_eq("resume_running", running, 1);
    en = 1'b1;
    wait_drain("resume_drain");

    // Short reset pulse while clk_out is high.
    do_reset();
    cfg_write(16'd3, 1'b1);
    measure_rise(lat);
    chk_eq("pulse_rise_lat", lat, 4);
    mon_en = 1'b0;
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk_eq("pulse_clk_out", clk_out, 0);
    chk_eq("pulse_running", running, 0);
    chk_eq("pulse_cfg_ready", cfg_ready, 1);
    #1 rst_n = 1'b1;
    @(negedge clk_in);
    chk_eq("pulse_restart", running, 1);
    measure_rise(lat);
    chk_eq("pulse_default_h", lat, 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
